life_row_engine: RTL and testbench

//  Computes the next Game-of-Life generation of one 640-cell display row, streamed as 16-bit words.

---
 rtl/life_pkg.sv | 17 +
 rtl/life_word_rule.sv | 50 +++++
 rtl/life_row_engine.sv | 200 ++++++++++++++++++++
 tb/tb_life_row_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants and state encoding for the Game-of-Life row engine.
// Cell rule defaults are B3/S23; a mask bit n covers a cell with n live neighbours.
package life_pkg;

    localparam int WIDTH = 16;
    localparam int WORDS = 40;
    localparam logic [8:0] BIRTH_MASK_DEF   = 9'b000001000;
    localparam logic [8:0] SURVIVE_MASK_DEF = 9'b000001100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } life_state_e;

endpackage

// File: rtl/life_word_rule.sv
// Combinational next-generation rule for one WIDTH-cell word of the middle row,
// using the neighbouring words only for the single column across each word boundary.
module life_word_rule #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] prevAbove_i,
    input  logic [WIDTH-1:0] prevCur_i,
    input  logic [WIDTH-1:0] prevBelow_i,
    input  logic [WIDTH-1:0] currAbove_i,
    input  logic [WIDTH-1:0] currCur_i,
    input  logic [WIDTH-1:0] currBelow_i,
    input  logic [WIDTH-1:0] nextAbove_i,
    input  logic [WIDTH-1:0] nextCur_i,
    input  logic [WIDTH-1:0] nextBelow_i,
    input  logic [8:0]       birthMask_i,
    input  logic [8:0]       surviveMask_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH+1:0] aboveExt;
    logic [WIDTH+1:0] curExt;
    logic [WIDTH+1:0] belowExt;
    logic [15:0]      birthPad;
    logic [15:0]      survivePad;
    logic [3:0]       count;
    logic             unusedBits;

    // Bit 0 of each extended row is column -1 of this word, bit WIDTH+1 is column WIDTH.
    assign aboveExt = {nextAbove_i[0], currAbove_i, prevAbove_i[WIDTH-1]};
    assign curExt   = {nextCur_i[0],   currCur_i,   prevCur_i[WIDTH-1]};
    assign belowExt = {nextBelow_i[0], currBelow_i, prevBelow_i[WIDTH-1]};

    assign birthPad   = {7'b0, birthMask_i};
    assign survivePad = {7'b0, surviveMask_i};

    assign unusedBits = ^{prevAbove_i[WIDTH-2:0], prevCur_i[WIDTH-2:0], prevBelow_i[WIDTH-2:0],
                          nextAbove_i[WIDTH-1:1], nextCur_i[WIDTH-1:1], nextBelow_i[WIDTH-1:1]};

    always_comb begin
        word_o = '0;
        count  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = 4'(aboveExt[i]) + 4'(aboveExt[i+1]) + 4'(aboveExt[i+2])
                  + 4'(curExt[i])                       + 4'(curExt[i+2])
                  + 4'(belowExt[i]) + 4'(belowExt[i+1]) + 4'(belowExt[i+2]);
            word_o[i] = curExt[i+1] ? survivePad[count] : birthPad[count];
        end
    end

endmodule

// File: rtl/life_row_engine.sv
// Streams one display row through a two-word window and emits next-generation words.
// Define ROW_POPCOUNT_EN to accumulate the live-cell count of each completed row on liveCount.
module life_row_engine
    import life_pkg::*;
#(
    parameter logic [8:0] BIRTH_MASK   = BIRTH_MASK_DEF,
    parameter logic [8:0] SURVIVE_MASK = SURVIVE_MASK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inAbove,
    input  logic [WIDTH-1:0] inCur,
    input  logic [WIDTH-1:0] inBelow,
    input  logic             inFirst,
    input  logic             inLast,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [5:0]       outIndex,
    output logic             outLast,
    output logic             protoErr,
    output logic [9:0]       liveCount
);

    localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);

    // Row order inside a window word: [0] above, [1] current, [2] below.
    life_state_e             state_q, state_d;
    logic [2:0][WIDTH-1:0]   prev_q, prev_d;
    logic [2:0][WIDTH-1:0]   curr_q, curr_d;
    logic [5:0]              wordIdx_q, wordIdx_d;
    logic                    protoErr_q, protoErr_d;
    logic                    outValid_q;
    logic [WIDTH-1:0]        outData_q;
    logic [5:0]              outIndex_q;
    logic                    outLast_q;

    logic [2:0][WIDTH-1:0]   beat;
    logic [2:0][WIDTH-1:0]   ruleNext;
    logic [WIDTH-1:0]        ruleWord;
    logic                    slotFree;
    logic                    loadOut;
    logic                    lastOut;

    assign beat     = {inBelow, inCur, inAbove};
    assign slotFree = !outValid_q || outReady;

    // The incoming beat acts as the right-hand window word, so word k is
    // produced in the same cycle that beat k+1 is accepted.
    life_word_rule #(.WIDTH(WIDTH)) u_rule (
        .prevAbove_i   (prev_q[0]),
        .prevCur_i     (prev_q[1]),
        .prevBelow_i   (prev_q[2]),
        .currAbove_i   (curr_q[0]),
        .currCur_i     (curr_q[1]),
        .currBelow_i   (curr_q[2]),
        .nextAbove_i   (ruleNext[0]),
        .nextCur_i     (ruleNext[1]),
        .nextBelow_i   (ruleNext[2]),
        .birthMask_i   (BIRTH_MASK),
        .surviveMask_i (SURVIVE_MASK),
        .word_o        (ruleWord)
    );

    // PRIME also waits for a free output slot so a still-pending final word
    // of the previous row is never overwritten.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        curr_d     = curr_q;
        wordIdx_d  = wordIdx_q;
        protoErr_d = protoErr_q;
        inReady    = 1'b0;
        ruleNext   = beat;
        loadOut    = 1'b0;
        lastOut    = 1'b0;
        unique case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    if (inFirst) begin
                        prev_d    = '0;
                        curr_d    = beat;
                        wordIdx_d = '0;
                        state_d   = PRIME;
                        if (inLast) protoErr_d = 1'b1;
                    end else begin
                        protoErr_d = 1'b1;
                    end
                end
            end
            PRIME, STREAM: begin
                inReady = slotFree;
                if (inValid && slotFree) begin
                    if (inFirst) begin
                        protoErr_d = 1'b1;
                        prev_d     = '0;
                        curr_d     = beat;
                        wordIdx_d  = '0;
                        state_d    = PRIME;
                    end else begin
                        loadOut   = 1'b1;
                        prev_d    = curr_q;
                        curr_d    = beat;
                        wordIdx_d = wordIdx_q + 6'd1;
                        state_d   = STREAM;
                        if (inLast) begin
                            state_d = FLUSH;
                            if (wordIdx_q != LAST_IDX - 6'd1) protoErr_d = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                ruleNext = '0;
                if (slotFree) begin
                    loadOut = 1'b1;
                    lastOut = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            curr_q     <= '0;
            wordIdx_q  <= '0;
            protoErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            curr_q     <= curr_d;
            wordIdx_q  <= wordIdx_d;
            protoErr_q <= protoErr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outIndex_q <= '0;
            outLast_q  <= 1'b0;
        end else if (loadOut) begin
            outValid_q <= 1'b1;
            outData_q  <= ruleWord;
            outIndex_q <= wordIdx_q;
            outLast_q  <= lastOut;
        end else if (outReady) begin
            outValid_q <= 1'b0;
        end
    end

    assign outValid = outValid_q;
    assign outData  = outData_q;
    assign outIndex = outIndex_q;
    assign outLast  = outLast_q;
    assign protoErr = protoErr_q;

`ifdef ROW_POPCOUNT_EN
    logic [9:0] acc_q;
    logic [9:0] liveCount_q;
    logic [9:0] wordPop;

    always_comb begin
        wordPop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wordPop = wordPop + 10'(ruleWord[i]);
        end
    end

    // A fresh row load (or restart) zeroes the running sum before word 0 arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            liveCount_q <= '0;
        end else if (state_d == PRIME && !loadOut) begin
            acc_q <= '0;
        end else if (loadOut) begin
            if (lastOut) begin
                liveCount_q <= acc_q + wordPop;
                acc_q       <= '0;
            end else begin
                acc_q <= acc_q + wordPop;
            end
        end
    end

    assign liveCount = liveCount_q;
`else
    assign liveCount = '0;
`endif

endmodule

// File: tb/tb_life_row_engine.sv
// Bench for life_row_engine: directed rows checked against a cell-level Game-of-Life model.
// Also builds with ROW_POPCOUNT_EN defined, in which case liveCount is checked per row.
module tb_life_row_engine;

    localparam int NW = 40;
    localparam int NC = NW * 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [15:0] inAbove = '0;
    logic [15:0] inCur = '0;
    logic [15:0] inBelow = '0;
    logic        inFirst = 1'b0;
    logic        inLast = 1'b0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [15:0] outData;
    logic [5:0]  outIndex;
    logic        outLast;
    logic        protoErr;
    logic [9:0]  liveCount;

    life_row_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .inAbove   (inAbove),
        .inCur     (inCur),
        .inBelow   (inBelow),
        .inFirst   (inFirst),
        .inLast    (inLast),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outIndex  (outIndex),
        .outLast   (outLast),
        .protoErr  (protoErr),
        .liveCount (liveCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          idx;
        bit          last;
        int          live;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rowA[NW];
    logic [15:0] rowC[NW];
    logic [15:0] rowB[NW];
    logic [15:0] gotData[NW];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int cellOf(input int which, input int col, input int nCells);
        logic [15:0] w;
        if (col < 0 || col >= nCells) return 0;
        case (which)
            0:       w = rowA[col / 16];
            1:       w = rowC[col / 16];
            default: w = rowB[col / 16];
        endcase
        return int'(w[col % 16]);
    endfunction

    // Plain B3/S23 on the cell grid; cells past either end of the row are dead.
    function automatic logic [15:0] modelWord(input int k, input int nWords);
        logic [15:0] res;
        int          col, n, live;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            col = k * 16 + i;
            n = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if (!(dr == 1 && dc == 0)) n += cellOf(dr, col + dc, nWords * 16);
            live = cellOf(1, col, nWords * 16);
            res[i] = (live == 1) ? (n == 2 || n == 3) : (n == 3);
        end
        return res;
    endfunction

    task automatic expectRow(input int n);
        exp_t e;
        int   total = 0;
        for (int k = 0; k < n; k++) begin
            e.data = modelWord(k, n);
            total += $countones(e.data);
            e.idx  = k;
            e.last = (k == n - 1);
`ifdef ROW_POPCOUNT_EN
            e.live = total;
`else
            e.live = 0;
`endif
            expQ.push_back(e);
        end
    endtask

    task automatic clearRows();
        for (int k = 0; k < NW; k++) begin
            rowA[k] = '0; rowC[k] = '0; rowB[k] = '0;
        end
    endtask

    task automatic randomRows();
        for (int k = 0; k < NW; k++) begin
            rowA[k] = 16'($urandom); rowC[k] = 16'($urandom); rowB[k] = 16'($urandom);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] c, input logic [15:0] b,
                                 input logic first, input logic last);
        int waitCycles = 0;
        inAbove = a; inCur = c; inBelow = b;
        inFirst = first; inLast = last; inValid = 1'b1;
        forever begin
            @(negedge clk);
            if (inReady === 1'b1) break;
            waitCycles++;
            if (waitCycles > 200) begin
                checks++; errors++;
                $display("[TB] FAIL inReadyTimeout: got 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic sendRow(input int n);
        for (int k = 0; k < n; k++) applyStimulus(rowA[k], rowC[k], rowB[k], k == 0, k == n - 1);
        inValid = 1'b0; inFirst = 1'b0; inLast = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (expQ.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        checkOutput("drainEmpty", expQ.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted output word is compared, and a word held
    // under backpressure must not change until it is taken.
    exp_t        e;
    logic        holdPending = 1'b0;
    logic [15:0] heldData;
    logic [5:0]  heldIdx;
    logic        heldLast;

    always @(negedge clk) begin
        if (!rst_n) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("holdValid", outValid, 1);
                checkOutput("holdData", outData, heldData);
                checkOutput("holdIndex", outIndex, heldIdx);
                checkOutput("holdLast", outLast, heldLast);
            end
            holdPending = 1'b0;
            if (outValid === 1'b1) begin
                if (outReady) begin
                    if (expQ.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpectedWord: got index %0d expected none", outIndex);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("outData", outData, e.data);
                        checkOutput("outIndex", outIndex, e.idx);
                        checkOutput("outLast", outLast, e.last);
                        if (e.last) checkOutput("liveCount", liveCount, e.live);
                        if (outIndex < NW) gotData[outIndex] = outData;
                    end
                end else begin
                    holdPending = 1'b1;
                    heldData = outData; heldIdx = outIndex; heldLast = outLast;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        clearRows();
        repeat (2) @(negedge clk);
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstOutData", outData, 0);
        checkOutput("rstOutIndex", outIndex, 0);
        checkOutput("rstOutLast", outLast, 0);
        checkOutput("rstProtoErr", protoErr, 0);
        checkOutput("rstLiveCount", liveCount, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idleReady", inReady, 1);
        @(posedge clk); #1;

        // Blinker: the middle row and both rows next to it.
        rowC[2] = 16'h0007;
        checkOutput("modelBlinker", modelWord(2, NW), 16'h0002);
        expectRow(NW); sendRow(NW); drain();
        checkOutput("blinkerMid", gotData[2], 16'h0002);
        clearRows(); rowB[2] = 16'h0007;
        expectRow(NW); sendRow(NW); drain();
        checkOutput("blinkerAbove", gotData[2], 16'h0002);
        clearRows(); rowA[2] = 16'h0007;
        expectRow(NW); sendRow(NW); drain();
        checkOutput("blinkerBelow", gotData[2], 16'h0002);

        // Word boundary between columns 15 and 16.
        clearRows();
        rowA[0] = 16'h8000; rowC[0] = 16'h8000; rowC[1] = 16'h0001; rowB[0] = 16'h8000;
        expectRow(NW); sendRow(NW); drain();
        checkOutput("boundaryW0", gotData[0], 16'hC000);
        checkOutput("boundaryW1", gotData[1], 16'h0001);

        // Row edges do not wrap.
        clearRows(); rowC[0] = 16'h0003; rowA[0] = 16'h0001;
        expectRow(NW); sendRow(NW); drain();
        checkOutput("edgeW0", gotData[0], 16'h0003);
        checkOutput("edgeW39", gotData[39], 16'h0000);

        // Backpressure mid-row.
        randomRows(); expectRow(NW);
        fork
            sendRow(NW);
            begin
                repeat (15) @(posedge clk);
                #1 outReady = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stallInReady", inReady, 0);
                end
                @(posedge clk); #1 outReady = 1'b1;
            end
        join
        drain();

        // Three back-to-back rows: only the flush cycle separates them.
        t0 = int'($time);
        for (int r = 0; r < 3; r++) begin
            randomRows(); expectRow(NW); sendRow(NW);
        end
        checkOutput("b2bCycles", (int'($time) - t0) / 10, 3 * NW + 2);
        drain();

        // Saturated rows.
        for (int k = 0; k < NW; k++) begin
            rowA[k] = 16'hFFFF; rowC[k] = 16'hFFFF; rowB[k] = 16'hFFFF;
        end
        checkOutput("modelAllOnes", modelWord(0, NW), 16'h0000);
        expectRow(NW); sendRow(NW); drain();
        checkOutput("protoClean", protoErr, 0);

        // Short row ending at word 10.
        randomRows(); expectRow(11); sendRow(11); drain();
        checkOutput("protoShort", protoErr, 1);

        // Reset in the middle of a row, then a clean row.
        randomRows(); expectRow(NW);
        for (int k = 0; k < 20; k++) applyStimulus(rowA[k], rowC[k], rowB[k], k == 0, 1'b0);
        inValid = 1'b0; inFirst = 1'b0;
        rst_n = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midRstValid", outValid, 0);
        checkOutput("midRstIndex", outIndex, 0);
        checkOutput("midRstProto", protoErr, 0);
        checkOutput("midRstLive", liveCount, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        randomRows(); expectRow(NW); sendRow(NW); drain();

        // Beat without inFirst while idle is dropped.
        applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("protoDrop", protoErr, 1);
        repeat (3) @(negedge clk);
        checkOutput("dropNoOutput", outValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
